mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of a fixed-latency single-port memory.
// Optional macro COTM32_MEM_ARB_RR_EN: round-robin on contention instead of fixed LS priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_if_req,
    input  logic [ADDR_WIDTH-1:0]   i_if_addr,
    output logic                    o_if_gnt,
    output logic                    o_if_rvalid,
    output logic [DATA_WIDTH-1:0]   o_if_rdata,
    input  logic                    i_ls_req,
    input  logic                    i_ls_we,
    input  logic [ADDR_WIDTH-1:0]   i_ls_addr,
    input  logic [DATA_WIDTH-1:0]   i_ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_ls_wstrb,
    output logic                    o_ls_gnt,
    output logic                    o_ls_rvalid,
    output logic [DATA_WIDTH-1:0]   o_ls_rdata,
    output logic                    o_mem_en,
    output logic                    o_mem_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
    output logic [1:0]              o_state
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

    if (MEM_LATENCY < 1) begin : g_bad_latency
        $error("mem_arbiter: MEM_LATENCY must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nxt;
    logic                    owner_ls;
    logic                    lat_we;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [SW-1:0]           lat_wstrb;
    logic [DATA_WIDTH-1:0]   if_rdata_q;
    logic [DATA_WIDTH-1:0]   ls_rdata_q;
    logic                    gnt_if;
    logic                    gnt_ls;
    logic                    gnt_any;
    logic                    busy;

    // Handshake: a requester holds req and operands until it sees gnt; gnt is a
    // same-cycle combinational answer in IDLE and the transfer happens on that edge.
`ifdef COTM32_MEM_ARB_RR_EN
    logic last_ls;

    always_comb begin
        gnt_if = 1'b0;
        gnt_ls = 1'b0;
        if (state == IDLE && !i_rst) begin
            if (i_if_req && i_ls_req) begin
                gnt_ls = !last_ls;
                gnt_if = last_ls;
            end else begin
                gnt_if = i_if_req;
                gnt_ls = i_ls_req;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_ls <= 1'b1;
        end else if (gnt_if || gnt_ls) begin
            last_ls <= gnt_ls;
        end
    end
`else
    always_comb begin
        gnt_if = 1'b0;
        gnt_ls = 1'b0;
        if (state == IDLE && !i_rst) begin
            gnt_ls = i_ls_req;
            gnt_if = i_if_req && !i_ls_req;
        end
    end
`endif

    assign gnt_any = gnt_if || gnt_ls;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Fetches are always reads with no strobes; only LS operands are captured.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            owner_ls  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
        end else if (gnt_any) begin
            owner_ls  <= gnt_ls;
            lat_we    <= gnt_ls && i_ls_we;
            lat_addr  <= gnt_ls ? i_ls_addr : i_if_addr;
            lat_wdata <= gnt_ls ? i_ls_wdata : '0;
            lat_wstrb <= gnt_ls ? i_ls_wstrb : '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else if (state == BUSY && cnt == '0) begin
            if (owner_ls) begin
                ls_rdata_q <= lat_we ? '0 : i_mem_rdata;
            end else begin
                if_rdata_q <= i_mem_rdata;
            end
        end
    end

    assign busy        = (state == BUSY);
    assign o_if_gnt    = gnt_if;
    assign o_ls_gnt    = gnt_ls;
    assign o_if_rvalid = (state == RESP) && !owner_ls;
    assign o_ls_rvalid = (state == RESP) && owner_ls;
    assign o_if_rdata  = if_rdata_q;
    assign o_ls_rdata  = ls_rdata_q;
    assign o_mem_en    = busy;
    assign o_mem_we    = busy && lat_we;
    assign o_mem_addr  = busy ? lat_addr : '0;
    assign o_mem_wdata = busy ? lat_wdata : '0;
    assign o_mem_wstrb = busy ? lat_wstrb : '0;
    assign o_state     = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-timing reference model; a second instance runs with MEM_LATENCY=1.
module tb_mem_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // instance A (MEM_LATENCY = 2)
    logic        i_if_req, i_ls_req, i_ls_we;
    logic [31:0] i_if_addr, i_ls_addr, i_ls_wdata, i_mem_rdata;
    logic [3:0]  i_ls_wstrb;
    logic        o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid, o_mem_en, o_mem_we;
    logic [31:0] o_if_rdata, o_ls_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic [1:0]  o_state;

    // instance B (MEM_LATENCY = 1)
    logic        i_if_req_b, i_ls_req_b, i_ls_we_b;
    logic [31:0] i_if_addr_b, i_ls_addr_b, i_ls_wdata_b, i_mem_rdata_b;
    logic [3:0]  i_ls_wstrb_b;
    logic        o_if_gnt_b, o_if_rvalid_b, o_ls_gnt_b, o_ls_rvalid_b, o_mem_en_b, o_mem_we_b;
    logic [31:0] o_if_rdata_b, o_ls_rdata_b, o_mem_addr_b, o_mem_wdata_b;
    logic [3:0]  o_mem_wstrb_b;
    logic [1:0]  o_state_b;

    int n_vec  = 0;
    int n_miss = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(L)) u_dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
        .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_ls_req(i_ls_req), .i_ls_we(i_ls_we), .i_ls_addr(i_ls_addr),
        .i_ls_wdata(i_ls_wdata), .i_ls_wstrb(i_ls_wstrb), .o_ls_gnt(o_ls_gnt),
        .o_ls_rvalid(o_ls_rvalid), .o_ls_rdata(o_ls_rdata),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
        .i_mem_rdata(i_mem_rdata), .o_state(o_state)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u_dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(i_if_req_b), .i_if_addr(i_if_addr_b), .o_if_gnt(o_if_gnt_b),
        .o_if_rvalid(o_if_rvalid_b), .o_if_rdata(o_if_rdata_b),
        .i_ls_req(i_ls_req_b), .i_ls_we(i_ls_we_b), .i_ls_addr(i_ls_addr_b),
        .i_ls_wdata(i_ls_wdata_b), .i_ls_wstrb(i_ls_wstrb_b), .o_ls_gnt(o_ls_gnt_b),
        .o_ls_rvalid(o_ls_rvalid_b), .o_ls_rdata(o_ls_rdata_b),
        .o_mem_en(o_mem_en_b), .o_mem_we(o_mem_we_b), .o_mem_addr(o_mem_addr_b),
        .o_mem_wdata(o_mem_wdata_b), .o_mem_wstrb(o_mem_wstrb_b),
        .i_mem_rdata(i_mem_rdata_b), .o_state(o_state_b)
    );

    logic [137:0] obs, obs_b;
    assign obs = {o_if_gnt, o_ls_gnt, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
                  o_mem_wstrb, o_if_rvalid, o_ls_rvalid, o_if_rdata, o_ls_rdata};
    assign obs_b = {o_if_gnt_b, o_ls_gnt_b, o_mem_en_b, o_mem_we_b, o_mem_addr_b, o_mem_wdata_b,
                    o_mem_wstrb_b, o_if_rvalid_b, o_ls_rvalid_b, o_if_rdata_b, o_ls_rdata_b};

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Memory returns real data only in the last access cycle, garbage otherwise.
    logic [3:0] en_run;
    always @(posedge clk or posedge rst) begin
        if (rst) en_run <= 4'd0;
        else     en_run <= o_mem_en ? en_run + 4'd1 : 4'd0;
    end
    assign i_mem_rdata   = (o_mem_en && en_run == 4'(L - 1)) ? memf(o_mem_addr)
                                                             : (32'hBAD0_0000 | {28'h0, en_run});
    assign i_mem_rdata_b = o_mem_en_b ? memf(o_mem_addr_b) : 32'hBAD1_0000;

    // Reference model: a granted transaction at age k cycles after its grant
    // drives memory for ages 1..L, responds at age L+1, frees the port at L+2.
    bit          m_active;
    int          m_age;
    bit          m_owner_ls, m_we, m_last_ls;
    logic [31:0] m_addr, m_wdata, m_if_rdata, m_ls_rdata;
    logic [3:0]  m_wstrb;

    function automatic logic [1:0] model_gnt();
        if (rst || m_active) return 2'b00;
        if (i_if_req && i_ls_req) begin
`ifdef COTM32_MEM_ARB_RR_EN
            return m_last_ls ? 2'b10 : 2'b01;
`else
            return 2'b01;
`endif
        end
        return {i_if_req, i_ls_req};
    endfunction

    function automatic logic [137:0] model_vec();
        logic [1:0] g;
        logic en, rvi, rvl;
        g   = model_gnt();
        en  = m_active && (m_age <= L);
        rvi = m_active && (m_age == L + 1) && !m_owner_ls;
        rvl = m_active && (m_age == L + 1) && m_owner_ls;
        return {g, en, en & m_we, en ? m_addr : 32'h0, en ? m_wdata : 32'h0,
                en ? m_wstrb : 4'h0, rvi, rvl, m_if_rdata, m_ls_rdata};
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [1:0] g;
        if (rst) begin
            m_active = 0; m_age = 0; m_last_ls = 1;
            m_if_rdata = 32'h0; m_ls_rdata = 32'h0;
        end else begin
            g = model_gnt();
            if (m_active) begin
                if (m_age == L) begin
                    if (m_owner_ls) m_ls_rdata = m_we ? 32'h0 : memf(m_addr);
                    else            m_if_rdata = memf(m_addr);
                end
                m_age++;
                if (m_age == L + 2) m_active = 0;
            end
            if (g != 2'b00) begin
                m_active   = 1;
                m_age      = 1;
                m_owner_ls = g[0];
                m_last_ls  = g[0];
                m_we       = g[0] & i_ls_we;
                m_addr     = g[0] ? i_ls_addr : i_if_addr;
                m_wdata    = g[0] ? i_ls_wdata : 32'h0;
                m_wstrb    = g[0] ? i_ls_wstrb : 4'h0;
            end
        end
    end

    task automatic idle_inputs();
        i_if_req = 0; i_if_addr = 32'h0;
        i_ls_req = 0; i_ls_we = 0; i_ls_addr = 32'h0; i_ls_wdata = 32'h0; i_ls_wstrb = 4'h0;
    endtask

    task automatic drive_if(input logic [31:0] addr);
        i_if_req = 1; i_if_addr = addr;
    endtask

    task automatic drive_ls(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb);
        i_ls_req = 1; i_ls_we = we; i_ls_addr = addr; i_ls_wdata = wdata; i_ls_wstrb = strb;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        i_if_req = 1; i_ls_req = 1;
        i_if_req_b = 1; i_ls_req_b = 1; i_if_addr_b = 32'h0; i_ls_we_b = 0;
        i_ls_addr_b = 32'h0; i_ls_wdata_b = 32'h0; i_ls_wstrb_b = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if (obs !== 138'h0) begin n_miss++; $display("FAIL reset_a: got %h want 0", obs); end
        n_vec++; if (obs_b !== 138'h0) begin n_miss++; $display("FAIL reset_b: got %h want 0", obs_b); end
        idle_inputs();
        i_if_req_b = 0; i_ls_req_b = 0;
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        n_vec++; if (obs !== 138'h0) begin n_miss++; $display("FAIL reset_release: got %h want 0", obs); end
    endtask

    task automatic test_single_fetch();
        @(posedge clk); #1; drive_if(32'h0000_0100);
        @(negedge clk);
        n_vec++; if ({o_if_gnt, o_ls_gnt} !== 2'b10) begin n_miss++; $display("FAIL fetch_gnt: got %b want 10", {o_if_gnt, o_ls_gnt}); end
        @(posedge clk); #1; i_if_req = 0; i_if_addr = 32'hFFFF_FFF0;
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            n_vec++;
            if ({o_mem_en, o_mem_we, o_mem_addr, o_mem_wstrb, o_if_gnt, o_if_rvalid} !== {2'b10, 32'h0000_0100, 4'h0, 2'b00}) begin
                n_miss++; $display("FAIL fetch_busy[%0d]: en=%b we=%b addr=%h strb=%h want en=1 we=0 addr=00000100 strb=0", k, o_mem_en, o_mem_we, o_mem_addr, o_mem_wstrb);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({o_if_rvalid, o_ls_rvalid, o_if_rdata, o_mem_en, o_mem_addr} !== {2'b10, 32'h0050_0093, 1'b0, 32'h0}) begin
            n_miss++; $display("FAIL fetch_resp: rvalid=%b rdata=%h en=%b want rvalid=1 rdata=00500093 en=0", o_if_rvalid, o_if_rdata, o_mem_en);
        end
        @(negedge clk);
        n_vec++;
        if ({o_if_rvalid, o_if_rdata} !== {1'b0, 32'h0050_0093}) begin
            n_miss++; $display("FAIL fetch_hold: rvalid=%b rdata=%h want 0/00500093", o_if_rvalid, o_if_rdata);
        end
    endtask

    task automatic test_store();
        logic        t_we[4];
        logic [31:0] t_addr[4], t_wdata[4], exp_rd;
        logic [3:0]  t_strb[4];
        t_we    = '{1'b1, 1'b1, 1'b0, 1'b1};
        t_addr  = '{32'h0000_2004, 32'h0000_3003, 32'h0000_4001, 32'h0000_5008};
        t_wdata = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_A5A5, 32'h0F0F_0F0F};
        t_strb  = '{4'hF, 4'h0, 4'h0, 4'h5};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; drive_ls(t_we[i], t_addr[i], t_wdata[i], t_strb[i]);
            @(negedge clk);
            n_vec++;
            if ({o_if_gnt, o_ls_gnt, o_ls_rvalid} !== 3'b010) begin
                n_miss++; $display("FAIL ls_gnt[%0d]: got %b want 010", i, {o_if_gnt, o_ls_gnt, o_ls_rvalid});
            end
            @(posedge clk); #1;
            i_ls_req = 0; i_ls_we = ~t_we[i]; i_ls_addr = ~t_addr[i]; i_ls_wdata = $urandom; i_ls_wstrb = ~t_strb[i];
            for (int k = 0; k < L; k++) begin
                @(negedge clk);
                n_vec++;
                if ({o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb} !== {1'b1, t_we[i], t_addr[i], t_wdata[i], t_strb[i]}) begin
                    n_miss++; $display("FAIL ls_busy[%0d.%0d]: en=%b we=%b addr=%h wdata=%h strb=%h want 1 %b %h %h %h", i, k, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb, t_we[i], t_addr[i], t_wdata[i], t_strb[i]);
                end
            end
            exp_rd = t_we[i] ? 32'h0 : memf(t_addr[i]);
            @(negedge clk);
            n_vec++;
            if ({o_ls_rvalid, o_if_rvalid, o_ls_rdata, o_if_rdata, o_mem_en, o_mem_we, o_mem_addr} !== {2'b10, exp_rd, 32'h0050_0093, 2'b00, 32'h0}) begin
                n_miss++; $display("FAIL ls_resp[%0d]: rvalid=%b ls_rdata=%h if_rdata=%h en=%b want 1 %h 00500093 0", i, o_ls_rvalid, o_ls_rdata, o_if_rdata, o_mem_en, exp_rd);
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0] order[4], exp_order[4];
        int gcyc[4];
        int ng;
`ifdef COTM32_MEM_ARB_RR_EN
        exp_order = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_order = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        @(posedge clk); #1; drive_if(32'h0000_0400);
        @(negedge clk);
        n_vec++; if (o_if_gnt !== 1'b1) begin n_miss++; $display("FAIL lone_fetch_gnt: got %b want 1", o_if_gnt); end
        @(posedge clk); #1; i_if_req = 0;
        repeat (L + 1) @(posedge clk);
        #1; drive_if(32'h0000_0500); drive_ls(1'b0, 32'h0000_0600, 32'h0, 4'h0);
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(negedge clk);
            if (o_if_gnt || o_ls_gnt) begin order[ng] = {o_if_gnt, o_ls_gnt}; gcyc[ng] = c; ng++; end
            @(posedge clk); #1;
        end
        idle_inputs();
        n_vec++; if (ng != 4) begin n_miss++; $display("FAIL contention_timeout: got %0d grants want 4", ng); end
        for (int i = 0; i < ng; i++) begin
            n_vec++;
            if (order[i] !== exp_order[i]) begin n_miss++; $display("FAIL contention_order[%0d]: got %b want %b", i, order[i], exp_order[i]); end
        end
        for (int i = 1; i < ng; i++) begin
            n_vec++;
            if (gcyc[i] - gcyc[i-1] != L + 2) begin n_miss++; $display("FAIL contention_spacing[%0d]: got %0d want %0d", i, gcyc[i] - gcyc[i-1], L + 2); end
        end
        repeat (L + 3) @(posedge clk);
    endtask

    task automatic test_reset_mid_busy();
        @(posedge clk); #1; drive_if(32'h0000_0200);
        @(negedge clk);
        n_vec++; if (o_if_gnt !== 1'b1) begin n_miss++; $display("FAIL rmb_gnt: got %b want 1", o_if_gnt); end
        @(posedge clk); #1; idle_inputs();
        #2; rst = 1; i_if_req = 1; i_ls_req = 1;
        #1;
        n_vec++; if (obs !== 138'h0) begin n_miss++; $display("FAIL rmb_async: got %h want 0", obs); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if ({o_if_rvalid, o_ls_rvalid, o_if_gnt, o_ls_gnt, o_mem_en} !== 5'b0) begin
                n_miss++; $display("FAIL rmb_held[%0d]: got %b want 00000", k, {o_if_rvalid, o_ls_rvalid, o_if_gnt, o_ls_gnt, o_mem_en});
            end
        end
        idle_inputs();
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        n_vec++; if (obs !== 138'h0) begin n_miss++; $display("FAIL rmb_release: got %h want 0", obs); end
        @(posedge clk); #1; drive_if(32'h0000_0300);
        @(negedge clk);
        n_vec++; if (o_if_gnt !== 1'b1) begin n_miss++; $display("FAIL rmb_refetch_gnt: got %b want 1", o_if_gnt); end
        @(posedge clk); #1; idle_inputs();
        repeat (L) @(negedge clk);
        @(negedge clk);
        n_vec++;
        if ({o_if_rvalid, o_if_rdata} !== {1'b1, memf(32'h0000_0300)}) begin
            n_miss++; $display("FAIL rmb_refetch_resp: rvalid=%b rdata=%h want 1 %h", o_if_rvalid, o_if_rdata, memf(32'h0000_0300));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] held, a;
        logic        eg, ev, een;
        held = 32'h0;
        @(posedge clk); #1;
        a = $urandom; i_if_addr_b = a; i_if_req_b = 1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            eg  = (c % 3 == 0);
            een = (c % 3 == 1);
            ev  = (c % 3 == 2);
            if (eg) exp_q.push_back(memf(a));
            if (ev && exp_q.size() > 0) held = exp_q.pop_front();
            n_vec++;
            if ({o_if_gnt_b, o_mem_en_b, o_if_rvalid_b, o_ls_rvalid_b, o_if_rdata_b} !== {eg, een, ev, 1'b0, held}) begin
                n_miss++; $display("FAIL b2b cycle %0d: gnt=%b en=%b rvalid=%b rdata=%h want %b %b %b %h", c, o_if_gnt_b, o_mem_en_b, o_if_rvalid_b, o_if_rdata_b, eg, een, ev, held);
            end
            @(posedge clk); #1;
            if (eg) begin a = $urandom; i_if_addr_b = a; end
        end
        i_if_req_b = 0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_random();
        bit if_pend, ls_pend, gi, gl;
        if_pend = 0; ls_pend = 0;
        @(posedge clk); #1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            n_vec++;
            if (obs !== model_vec()) begin
                n_miss++; $display("FAIL random cycle %0d: got %h want %h", c, obs, model_vec());
            end
            gi = o_if_gnt; gl = o_ls_gnt;
            @(posedge clk); #1;
            if (gi) if_pend = 0;
            else if (if_pend && $urandom_range(0, 15) == 0) if_pend = 0;
            if (!if_pend) begin
                i_if_addr = $urandom;
                if ($urandom_range(0, 2) == 0) if_pend = 1;
            end
            i_if_req = if_pend;
            if (gl) ls_pend = 0;
            else if (ls_pend && $urandom_range(0, 15) == 0) ls_pend = 0;
            if (!ls_pend) begin
                i_ls_we    = 1'($urandom_range(0, 1));
                i_ls_addr  = $urandom;
                i_ls_wdata = $urandom;
                i_ls_wstrb = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) ls_pend = 1;
            end
            i_ls_req = ls_pend;
        end
        idle_inputs();
        repeat (L + 3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_contention();
        test_reset_mid_busy();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
